// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: state encoding and reference 2-input truth tables for gate_truth_checker.
package gate_chk_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;
   localparam logic [3:0] TT_AND2  = 4'b1000;
   localparam logic [3:0] TT_OR2   = 4'b1110;
   localparam logic [3:0] TT_NAND2 = 4'b0111;
   localparam logic [3:0] TT_NOR2  = 4'b0001;
   localparam logic [3:0] TT_XOR2  = 4'b0110;
endpackage

// File: rtl/gate_chk_settle_timer.sv
// gate_chk_settle_timer: loadable down-counter with zero flag that paces the settle time.
module gate_chk_settle_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       zero
);
   logic [3:0] cnt_q, cnt_d;
   assign zero = cnt_q == 4'd0;
   always_comb cnt_d = load ? load_val : (dec && !zero) ? cnt_q - 4'd1 : cnt_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: walks every input vector through a gate, compares against TRUTH.
// First-failure capture is built only when GATE_CHK_FAIL_CAPTURE_EN is defined.
module gate_truth_checker
   import gate_chk_pkg::*;
#(
   parameter int                 N_IN   = 2,
   parameter logic [2**N_IN-1:0] TRUTH  = TT_NAND2,
   parameter int                 SETTLE = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [N_IN-1:0] drive,
   input  logic            dut_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_cnt,
   output logic [N_IN-1:0] fail_vec,
   output logic            fail_valid
);
   localparam logic [N_IN-1:0] LAST_VEC  = '1;
   localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);
   localparam logic [N_IN:0]   ERR_ONE   = (N_IN + 1)'(1);
   localparam logic [3:0]      SETTLE_LD = 4'(SETTLE - 1);
   state_t          state_q, state_d;
   logic [N_IN-1:0] vec_q, vec_d, drive_q, drive_d;
   logic [N_IN:0]   err_q, err_d;
   logic            pass_q, pass_d, mismatch, run_start, tmr_load, tmr_zero;
   assign mismatch  = dut_out != TRUTH[vec_q];
   // DONE accepts start too, so a held start chains runs back to back
   assign run_start = (state_q == ST_IDLE || state_q == ST_DONE) && start;
   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      err_d    = err_q;
      pass_d   = pass_q;
      tmr_load = 1'b0;
      case (state_q)
         ST_SETTLE: state_d = tmr_zero ? ST_SAMPLE : ST_SETTLE;
         ST_SAMPLE: begin
            err_d = err_q + (mismatch ? ERR_ONE : '0);
            if (vec_q == LAST_VEC) begin
               state_d = ST_DONE;
               pass_d  = err_d == '0;
            end else begin
               state_d  = ST_SETTLE;
               vec_d    = vec_q + VEC_ONE;
               tmr_load = 1'b1;
            end
         end
         default: begin
            state_d = run_start ? ST_SETTLE : ST_IDLE;
            if (run_start) begin
               vec_d    = '0;
               err_d    = '0;
               pass_d   = 1'b0;
               tmr_load = 1'b1;
            end
         end
      endcase
      drive_d = (state_d == ST_SETTLE || state_d == ST_SAMPLE) ? vec_d : '0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= ST_IDLE;
         vec_q   <= '0;
         drive_q <= '0;
         err_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         drive_q <= drive_d;
         err_q   <= err_d;
         pass_q  <= pass_d;
      end
   gate_chk_settle_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (SETTLE_LD),
      .dec      (state_q == ST_SETTLE),
      .zero     (tmr_zero)
   );
`ifdef GATE_CHK_FAIL_CAPTURE_EN
   logic [N_IN-1:0] fvec_q;
   logic            fval_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         fvec_q <= '0;
         fval_q <= 1'b0;
      end else if (run_start) fval_q <= 1'b0;
      else if (state_q == ST_SAMPLE && mismatch && !fval_q) begin
         fvec_q <= vec_q;
         fval_q <= 1'b1;
      end
   assign fail_vec   = fvec_q;
   assign fail_valid = fval_q;
`else
   assign fail_vec   = '0;
   assign fail_valid = 1'b0;
`endif
   assign drive   = drive_q;
   assign busy    = state_q == ST_SETTLE || state_q == ST_SAMPLE;
   assign done    = state_q == ST_DONE;
   assign pass    = pass_q;
   assign err_cnt = err_q;
endmodule
